// File: rtl/regm_wb_arbiter.sv
// Write-back arbiter for the single regm write port: fixed priority with age-based promotion.
// Optional WB_ARB_STATS_EN adds per-requester grant counters and a conflict counter.
module regm_wb_arbiter #(
    parameter int NREQ     = 3,
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_hold,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_reg,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_reg,
    output logic [DW-1:0]        wr_data
`ifdef WB_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]   stat_grants,
    output logic [15:0]          stat_conflicts
`endif
);

    localparam int AGW = $clog2(MAX_WAIT + 1);
    localparam logic [AGW-1:0] AGE_MAX = AGW'(MAX_WAIT);

    logic [AGW-1:0] age [NREQ];
    logic [NREQ-1:0] grant;
    logic            any_grant;
    logic            multi_valid;
    logic [AW-1:0]   sel_reg;
    logic [DW-1:0]   sel_data;

    // Promoted (aged-out) requesters win over base priority; lowest index breaks ties.
    always_comb begin
        logic        starved;
        logic        found;
        int unsigned sidx;
        int unsigned lidx;
        int unsigned nvalid;
        starved  = 1'b0;
        found    = 1'b0;
        sidx     = 0;
        lidx     = 0;
        nvalid   = 0;
        grant    = '0;
        sel_reg  = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req_valid[i]) begin
                nvalid = nvalid + 1;
                if (!found) begin
                    found = 1'b1;
                    lidx  = i;
                end
                if (!starved && age[i] == AGE_MAX) begin
                    starved = 1'b1;
                    sidx    = i;
                end
            end
        end
        if (!rst && !wb_hold && found)
            grant[starved ? sidx : lidx] = 1'b1;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_reg  = req_reg[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
        any_grant   = |grant;
        multi_valid = (nvalid >= 2);
    end

    assign req_ready = grant;

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (rst)
                age[i] <= '0;
            else if (!wb_hold) begin
                if (!req_valid[i] || grant[i])
                    age[i] <= '0;
                else if (age[i] != AGE_MAX)
                    age[i] <= age[i] + 1'b1;
            end
        end
    end

    // Address/data hold their last value when idle; only wr_en drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_reg  <= '0;
            wr_data <= '0;
        end else if (any_grant) begin
            wr_en   <= (sel_reg != '0);
            wr_reg  <= sel_reg;
            wr_data <= sel_data;
        end else begin
            wr_en   <= 1'b0;
        end
    end

`ifdef WB_ARB_STATS_EN
    // No grant is issued during hold, so gating on grant also freezes the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grants    <= '0;
            stat_conflicts <= '0;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (grant[i])
                    stat_grants[i*16 +: 16] <= stat_grants[i*16 +: 16] + 16'd1;
            end
            if (any_grant && multi_valid)
                stat_conflicts <= stat_conflicts + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regm_wb_arbiter.sv
// Directed self-checking bench for regm_wb_arbiter (default parameters: NREQ=3, DW=32, AW=5, MAX_WAIT=4).
module tb_regm_wb_arbiter;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_hold;
    logic [2:0]    req_valid;
    logic [14:0]   req_reg;
    logic [95:0]   req_data;
    logic [2:0]    req_ready;
    logic          wr_en;
    logic [4:0]    wr_reg;
    logic [31:0]   wr_data;
`ifdef WB_ARB_STATS_EN
    logic [47:0]   stat_grants;
    logic [15:0]   stat_conflicts;
`endif

    int vectors = 0;
    int errors  = 0;

    regm_wb_arbiter #(.NREQ(3), .DW(32), .AW(5), .MAX_WAIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_hold   (wb_hold),
        .req_valid (req_valid),
        .req_reg   (req_reg),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_reg    (wr_reg),
        .wr_data   (wr_data)
`ifdef WB_ARB_STATS_EN
        ,
        .stat_grants    (stat_grants),
        .stat_conflicts (stat_conflicts)
`endif
    );

    always #5 clk = ~clk;

    task automatic set_req(input int i, input logic v, input logic [4:0] r, input logic [31:0] d);
        req_valid[i]         = v;
        req_reg[i*5 +: 5]    = r;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wb_hold = 1'b0;
        req_valid = 3'b111;
        req_reg = {5'd3, 5'd2, 5'd1};
        req_data = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        for (int c = 0; c < 2; c++) begin
            #1;
            vectors++;
            if (req_ready !== 3'b000) begin
                errors++;
                $display("FAIL reset_ready cyc%0d: got %b want 000", c, req_ready);
            end
            step();
            vectors++;
            if (wr_en !== 1'b0) begin
                errors++;
                $display("FAIL reset_wr_en cyc%0d: got %b want 0", c, wr_en);
            end
        end
        vectors++;
        if (wr_reg !== 5'd0 || wr_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_wr_regdata: got %0d/%h want 0/00000000", wr_reg, wr_data);
        end
        rst = 1'b0;
        req_valid = 3'b000;
        step();
    endtask

    task automatic test_single();
        set_req(1, 1'b1, 5'd8, 32'hDEADBEEF);
        #1;
        vectors++;
        if (req_ready !== 3'b010) begin
            errors++;
            $display("FAIL single_ready: got %b want 010", req_ready);
        end
        step();
        vectors++;
        if (wr_en !== 1'b1 || wr_reg !== 5'd8 || wr_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_write: got en=%b reg=%0d data=%h want 1/8/deadbeef", wr_en, wr_reg, wr_data);
        end
        set_req(1, 1'b0, 5'd0, 32'd0);
        #1;
        vectors++;
        if (req_ready !== 3'b000) begin
            errors++;
            $display("FAIL single_idle_ready: got %b want 000", req_ready);
        end
        step();
        vectors++;
        if (wr_en !== 1'b0 || wr_reg !== 5'd8 || wr_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_idle_hold: got en=%b reg=%0d data=%h want 0/8/deadbeef", wr_en, wr_reg, wr_data);
        end
    endtask

    task automatic test_priority();
        rst = 1'b1;
        req_valid = 3'b000;
        step();
        rst = 1'b0;
        set_req(0, 1'b1, 5'd3, 32'hAAAA_0003);
        set_req(2, 1'b1, 5'd4, 32'hCCCC_0004);
        #1;
        vectors++;
        if (req_ready !== 3'b001) begin
            errors++;
            $display("FAIL prio_first_ready: got %b want 001", req_ready);
        end
        step();
        vectors++;
        if (wr_en !== 1'b1 || wr_reg !== 5'd3 || wr_data !== 32'hAAAA_0003) begin
            errors++;
            $display("FAIL prio_first_write: got en=%b reg=%0d data=%h want 1/3/aaaa0003", wr_en, wr_reg, wr_data);
        end
        set_req(0, 1'b0, 5'd0, 32'd0);
        #1;
        vectors++;
        if (req_ready !== 3'b100) begin
            errors++;
            $display("FAIL prio_second_ready: got %b want 100", req_ready);
        end
        step();
        vectors++;
        if (wr_en !== 1'b1 || wr_reg !== 5'd4 || wr_data !== 32'hCCCC_0004) begin
            errors++;
            $display("FAIL prio_second_write: got en=%b reg=%0d data=%h want 1/4/cccc0004", wr_en, wr_reg, wr_data);
        end
        set_req(2, 1'b0, 5'd0, 32'd0);
        step();
        vectors++;
        if (wr_en !== 1'b0) begin
            errors++;
            $display("FAIL prio_idle: got en=%b want 0", wr_en);
        end
`ifdef WB_ARB_STATS_EN
        vectors++;
        if (stat_grants !== {16'd1, 16'd0, 16'd1} || stat_conflicts !== 16'd1) begin
            errors++;
            $display("FAIL stats: got grants=%h conflicts=%0d want 000100000001/1", stat_grants, stat_conflicts);
        end
`endif
    endtask

    task automatic test_starvation();
        logic [4:0] exp_reg;
        set_req(2, 1'b1, 5'd9, 32'hC0DE_0009);
        for (int k = 0; k < 4; k++) begin
            exp_reg = 5'd10 + 5'(k);
            set_req(0, 1'b1, exp_reg, 32'h0);
            #1;
            vectors++;
            if (req_ready !== 3'b001) begin
                errors++;
                $display("FAIL starve_deny%0d: got %b want 001", k, req_ready);
            end
            step();
            vectors++;
            if (wr_reg !== exp_reg) begin
                errors++;
                $display("FAIL starve_deny_reg%0d: got %0d want %0d", k, wr_reg, exp_reg);
            end
        end
        set_req(0, 1'b1, 5'd14, 32'h0);
        #1;
        vectors++;
        if (req_ready !== 3'b100) begin
            errors++;
            $display("FAIL starve_promote: got %b want 100", req_ready);
        end
        step();
        vectors++;
        if (wr_en !== 1'b1 || wr_reg !== 5'd9 || wr_data !== 32'hC0DE_0009) begin
            errors++;
            $display("FAIL starve_promote_write: got en=%b reg=%0d data=%h want 1/9/c0de0009", wr_en, wr_reg, wr_data);
        end
        set_req(2, 1'b0, 5'd0, 32'd0);
        #1;
        vectors++;
        if (req_ready !== 3'b001) begin
            errors++;
            $display("FAIL starve_after: got %b want 001", req_ready);
        end
        step();
        vectors++;
        if (wr_reg !== 5'd14) begin
            errors++;
            $display("FAIL starve_after_reg: got %0d want 14", wr_reg);
        end
        set_req(0, 1'b0, 5'd0, 32'd0);
        step();
    endtask

    task automatic test_zero_reg();
        set_req(1, 1'b1, 5'd0, 32'h5555_AAAA);
        #1;
        vectors++;
        if (req_ready !== 3'b010) begin
            errors++;
            $display("FAIL zero_ready: got %b want 010", req_ready);
        end
        step();
        vectors++;
        if (wr_en !== 1'b0 || wr_reg !== 5'd0 || wr_data !== 32'h5555_AAAA) begin
            errors++;
            $display("FAIL zero_write: got en=%b reg=%0d data=%h want 0/0/5555aaaa", wr_en, wr_reg, wr_data);
        end
        set_req(1, 1'b0, 5'd0, 32'd0);
        step();
    endtask

    task automatic test_hold();
        // req2 accrues age 3, then hold must freeze it: after hold req0 still wins once.
        set_req(0, 1'b1, 5'd1, 32'h0000_0101);
        set_req(2, 1'b1, 5'd2, 32'h0000_0202);
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++;
            if (req_ready !== 3'b001) begin
                errors++;
                $display("FAIL hold_pre%0d: got %b want 001", k, req_ready);
            end
            step();
        end
        wb_hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++;
            if (req_ready !== 3'b000) begin
                errors++;
                $display("FAIL hold_ready%0d: got %b want 000", k, req_ready);
            end
            step();
            vectors++;
            if (wr_en !== 1'b0) begin
                errors++;
                $display("FAIL hold_wr_en%0d: got %b want 0", k, wr_en);
            end
        end
        wb_hold = 1'b0;
        #1;
        vectors++;
        if (req_ready !== 3'b001) begin
            errors++;
            $display("FAIL hold_age_frozen: got %b want 001", req_ready);
        end
        step();
        vectors++;
        if (wr_en !== 1'b1 || wr_reg !== 5'd1) begin
            errors++;
            $display("FAIL hold_release_write: got en=%b reg=%0d want 1/1", wr_en, wr_reg);
        end
        #1;
        vectors++;
        if (req_ready !== 3'b100) begin
            errors++;
            $display("FAIL hold_promote: got %b want 100", req_ready);
        end
        step();
        vectors++;
        if (wr_reg !== 5'd2 || wr_data !== 32'h0000_0202) begin
            errors++;
            $display("FAIL hold_promote_write: got reg=%0d data=%h want 2/00000202", wr_reg, wr_data);
        end
        req_valid = 3'b000;
        step();
    endtask

    task automatic test_back_to_back();
        set_req(0, 1'b1, 5'd6, 32'h0000_0001);
        set_req(1, 1'b1, 5'd6, 32'h0000_0002);
        set_req(2, 1'b1, 5'd11, 32'h0000_0003);
        for (int k = 0; k < 3; k++) begin
            logic [2:0]  exp_rdy;
            logic [4:0]  exp_reg;
            logic [31:0] exp_dat;
            exp_rdy = 3'b001 << k;
            exp_reg = (k == 2) ? 5'd11 : 5'd6;
            exp_dat = 32'(k + 1);
            #1;
            vectors++;
            if (req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL b2b_ready%0d: got %b want %b", k, req_ready, exp_rdy);
            end
            step();
            vectors++;
            if (wr_en !== 1'b1 || wr_reg !== exp_reg || wr_data !== exp_dat) begin
                errors++;
                $display("FAIL b2b_write%0d: got en=%b reg=%0d data=%h want 1/%0d/%h", k, wr_en, wr_reg, wr_data, exp_reg, exp_dat);
            end
            req_valid[k] = 1'b0;
        end
        step();
    endtask

    task automatic test_reset_mid();
        set_req(1, 1'b1, 5'd7, 32'h7777_0007);
        rst = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_ready: got %b want 000", req_ready);
        end
        step();
        vectors++;
        if (wr_en !== 1'b0 || wr_reg !== 5'd0) begin
            errors++;
            $display("FAIL rstmid_discard: got en=%b reg=%0d want 0/0", wr_en, wr_reg);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (req_ready !== 3'b010) begin
            errors++;
            $display("FAIL rstmid_represent: got %b want 010", req_ready);
        end
        step();
        vectors++;
        if (wr_en !== 1'b1 || wr_reg !== 5'd7 || wr_data !== 32'h7777_0007) begin
            errors++;
            $display("FAIL rstmid_write: got en=%b reg=%0d data=%h want 1/7/77770007", wr_en, wr_reg, wr_data);
        end
        req_valid = 3'b000;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_starvation();
        test_zero_reg();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
